// File: rtl/bg_pkg.sv
// Shared constants for the background grass VRAM: geometry, word packing and
// writer FSM encoding. The scanline reader imports this too.
package bg_pkg;

  localparam int BG_TOP_ROW       = 300;
  localparam int BG_ROWS          = 128;
  localparam int BG_WORDS_PER_ROW = 16;
  localparam int BG_PIX_PER_WORD  = 3;
  localparam int BG_COLS          = 48;
  localparam int BG_IDX_W         = 3;

  localparam logic [2:0] BG_SKY_IDX    = 3'd5;
  localparam logic [2:0] BG_GROUND_IDX = 3'd7;

  // Slot 0 is the leftmost pixel and sits in the top bits of the word.
  localparam int BG_SLOT0_LSB = 6;
  localparam int BG_SLOT1_LSB = 3;
  localparam int BG_SLOT2_LSB = 0;

  typedef enum logic {
    CMD_PIXEL = 1'b0,
    CMD_FILL  = 1'b1
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_FILL
  } state_t;

  function automatic int slot_lsb(input logic [1:0] slot);
    case (slot)
      2'd0:    return BG_SLOT0_LSB;
      2'd1:    return BG_SLOT1_LSB;
      default: return BG_SLOT2_LSB;
    endcase
  endfunction

endpackage

// File: rtl/bg_pixel_merge.sv
// Column decode (col -> word, slot) by table lookup, and replacement of one
// 3-bit slot inside a 9-bit VRAM word.
module bg_pixel_merge
  import bg_pkg::*;
(
  input  logic [8:0] word_in,
  input  logic [5:0] col,
  input  logic [2:0] index,
  output logic [8:0] word_out,
  output logic [3:0] word_sel,
  output logic       col_ok
);

  logic [1:0] slot;

  // The loop unrolls into a 48-entry constant table; nothing divides at runtime.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    word_sel = '0;
    slot     = '0;
    col_ok   = 1'b0;
    for (int i = 0; i < BG_COLS; i++) begin
      if (col == 6'(i)) begin
        word_sel = 4'(i / BG_PIX_PER_WORD);
        slot     = 2'(i % BG_PIX_PER_WORD);
        col_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    word_out = word_in;
    word_out[slot_lsb(slot) +: BG_IDX_W] = index;
  end

endmodule

// File: rtl/bg_vram_writer.sv
// Write-side agent for the background grass VRAM: read-modify-write pixel
// updates and whole-memory fills, with registered VRAM port outputs.
module bg_vram_writer
  import bg_pkg::*;
#(
  parameter int RD_LAT        = 1,
  parameter int ROWS          = BG_ROWS,
  parameter int WORDS_PER_ROW = BG_WORDS_PER_ROW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_cmd,
  input  logic [6:0]  req_row,
  input  logic [5:0]  req_col,
  input  logic [2:0]  req_index,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        vram_en,
  output logic        vram_we,
  output logic [10:0] vram_addr,
  output logic [8:0]  vram_din,
  input  logic [8:0]  vram_dout
);

  localparam logic [10:0] FILL_LAST = 11'(ROWS * WORDS_PER_ROW - 1);
  localparam logic [1:0]  WAIT_LAST = 2'(RD_LAT - 1);

  state_t      state, state_nxt;
  logic [1:0]  wait_cnt, wait_cnt_nxt;
  logic [5:0]  col_q;
  logic [2:0]  idx_q;
  logic        en_nxt, we_nxt, done_nxt, err_nxt;
  logic [10:0] addr_nxt;
  logic [8:0]  din_nxt;
  logic [5:0]  merge_col;
  logic [8:0]  merged;
  logic [3:0]  word_sel;
  logic        col_ok;
  logic        accept;

  assign req_ready = (state == S_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  // One decoder serves both the acceptance check (live request) and the merge (captured column).
  assign merge_col = (state == S_IDLE) ? req_col : col_q;

  bg_pixel_merge u_merge (
    .word_in  (vram_dout),
    .col      (merge_col),
    .index    (idx_q),
    .word_out (merged),
    .word_sel (word_sel),
    .col_ok   (col_ok)
  );

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    en_nxt       = 1'b0;
    we_nxt       = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    addr_nxt     = vram_addr;
    din_nxt      = vram_din;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_cmd == CMD_FILL) begin
            state_nxt = S_FILL;
            en_nxt    = 1'b1;
            we_nxt    = 1'b1;
            addr_nxt  = '0;
            din_nxt   = {3{req_index}};
          end else if (!col_ok) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = S_RD;
            en_nxt    = 1'b1;
            addr_nxt  = {req_row, word_sel};
          end
        end
      end
      S_RD: begin
        state_nxt    = S_WAIT;
        wait_cnt_nxt = '0;
      end
      S_WAIT: begin
        // The read word is valid on the last wait cycle; merge it straight into the write data.
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_WR;
          en_nxt    = 1'b1;
          we_nxt    = 1'b1;
          din_nxt   = merged;
        end else begin
          wait_cnt_nxt = wait_cnt + 2'd1;
        end
      end
      S_WR: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
      S_FILL: begin
        if (vram_addr == FILL_LAST) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          en_nxt   = 1'b1;
          we_nxt   = 1'b1;
          addr_nxt = vram_addr + 11'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      vram_en   <= 1'b0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_din  <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      busy      <= (state_nxt != S_IDLE);
      done      <= done_nxt;
      err       <= err_nxt;
      vram_en   <= en_nxt;
      vram_we   <= we_nxt;
      vram_addr <= addr_nxt;
      vram_din  <= din_nxt;
      if (accept) begin
        col_q <= req_col;
        idx_q <= req_index;
      end
    end
  end

endmodule
